// File: rtl/telemetry_wconv_fifo.sv
// Single-clock FIFO: whole DIN_W words in, DOUT_W sub-words out (MS sub-word first).
// Level/almost flags are decoded from registered state; error pulses are registered.
module telemetry_wconv_fifo #(
  parameter int DIN_W     = 32,
  parameter int DOUT_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int FWFT      = 1,
  localparam int R        = DIN_W / DOUT_W,
  localparam int LW       = $clog2(DEPTH * R) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DIN_W-1:0]  din_i,
  input  logic              rd_en_i,
  output logic [DOUT_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [LW-1:0]     level_o,
  output logic              wr_err_o,
  output logic              rd_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (R > 1) ? $clog2(R) : 1;

  typedef logic [R-1:0][DOUT_W-1:0] entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              wr_err_q, rd_err_q;
  logic [DOUT_W-1:0] dout_q;

  logic              full, empty, wr_acc, rd_acc, last, rd_free;
  logic [LW-1:0]     level;
  logic [SW-1:0]     lane;
  logic [DOUT_W-1:0] head;

  // Readable sub-words: whole entries minus the sub-words already consumed from the head.
  assign level   = (LW'(cnt_q) * LW'(R)) - LW'(sel_q);
  assign full    = (cnt_q == PW'(DEPTH));
  assign empty   = (level == '0);
  assign wr_acc  = wr_en_i && !full;
  assign rd_acc  = rd_en_i && !empty;
  assign last    = (sel_q == SW'(R - 1));
  assign rd_free = rd_acc && last;

  // Packed lane R-1 holds the most-significant sub-word, which is read first.
  assign lane = SW'(R - 1) - sel_q;
  assign head = mem_q[rd_ptr_q[AW-1:0]][lane];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) begin
      if (last) begin
        sel_d    = '0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        sel_d    = sel_q + SW'(1);
      end
    end
    case ({wr_acc, rd_free})
      2'b10:   cnt_d = cnt_q + PW'(1);
      2'b01:   cnt_d = cnt_q - PW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_en_i && full;
      rd_err_q <= rd_en_i && empty;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= entry_t'(din_i);
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout_o = empty ? '0 : head;
      assign dout_q = '0;
    end else begin : g_std
      always_ff @(posedge clk_i) begin
        if (rst_i)       dout_q <= '0;
        else if (rd_acc) dout_q <= head;
      end
      assign dout_o = dout_q;
    end
  endgenerate

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (cnt_q >= PW'(DEPTH - AF_MARGIN));
  assign almost_empty_o = (level <= LW'(AE_MARGIN));
  assign level_o        = level;
  assign wr_err_o       = wr_err_q;
  assign rd_err_o       = rd_err_q;

endmodule

// File: tb/tb_telemetry_wconv_fifo.sv
// Bench for telemetry_wconv_fifo: FWFT and standard-read instances share stimulus and
// are checked against a sub-word queue model.
module tb_telemetry_wconv_fifo;
  localparam int DIN_W  = 32;
  localparam int DOUT_W = 16;
  localparam int DEPTH  = 16;
  localparam int AFM    = 2;
  localparam int AEM    = 2;
  localparam int R      = DIN_W / DOUT_W;
  localparam int LW     = $clog2(DEPTH * R) + 1;

  logic              clk = 1'b0;
  logic              rst, wr_en, rd_en;
  logic [DIN_W-1:0]  din;
  logic [DOUT_W-1:0] dout_f, dout_s;
  logic              full_f, empty_f, af_f, ae_f, werr_f, rerr_f;
  logic              full_s, empty_s, af_s, ae_s, werr_s, rerr_s;
  logic [LW-1:0]     level_f, level_s;

  always #5 clk = ~clk;

  telemetry_wconv_fifo #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH(DEPTH),
    .AF_MARGIN(AFM), .AE_MARGIN(AEM), .FWFT(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .din_i(din), .rd_en_i(rd_en),
    .dout_o(dout_f), .full_o(full_f), .empty_o(empty_f), .almost_full_o(af_f),
    .almost_empty_o(ae_f), .level_o(level_f), .wr_err_o(werr_f), .rd_err_o(rerr_f));

  telemetry_wconv_fifo #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH(DEPTH),
    .AF_MARGIN(AFM), .AE_MARGIN(AEM), .FWFT(0)) u_dut_std (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .din_i(din), .rd_en_i(rd_en),
    .dout_o(dout_s), .full_o(full_s), .empty_o(empty_s), .almost_full_o(af_s),
    .almost_empty_o(ae_s), .level_o(level_s), .wr_err_o(werr_s), .rd_err_o(rerr_s));

  // Model: queue of readable sub-words in read order.
  logic [DOUT_W-1:0] mq[$];
  logic              m_werr, m_rerr;
  logic [DOUT_W-1:0] m_dout_s;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_entries();
    return (mq.size() + R - 1) / R;
  endfunction

  task automatic check_all();
    int lvl;
    int ent;
    logic [31:0] hd;
    lvl = mq.size();
    ent = m_entries();
    hd  = (lvl != 0) ? 32'(mq[0]) : 32'd0;
    chk("level",   32'(level_f), 32'(lvl));
    chk("level_s", 32'(level_s), 32'(lvl));
    chk("full",    32'(full_f),  32'(ent == DEPTH));
    chk("full_s",  32'(full_s),  32'(ent == DEPTH));
    chk("empty",   32'(empty_f), 32'(lvl == 0));
    chk("empty_s", 32'(empty_s), 32'(lvl == 0));
    chk("afull",   32'(af_f),    32'(ent >= DEPTH - AFM));
    chk("afull_s", 32'(af_s),    32'(ent >= DEPTH - AFM));
    chk("aempty",  32'(ae_f),    32'(lvl <= AEM));
    chk("aempty_s",32'(ae_s),    32'(lvl <= AEM));
    chk("wr_err",  32'(werr_f),  32'(m_werr));
    chk("wr_err_s",32'(werr_s),  32'(m_werr));
    chk("rd_err",  32'(rerr_f),  32'(m_rerr));
    chk("rd_err_s",32'(rerr_s),  32'(m_rerr));
    chk("dout_fwft", 32'(dout_f), hd);
    chk("dout_std",  32'(dout_s), 32'(m_dout_s));
  endtask

  task automatic step(input logic we, input logic [DIN_W-1:0] d, input logic re);
    logic wacc, racc;
    wr_en = we; din = d; rd_en = re;
    wacc = we && (m_entries() != DEPTH);
    racc = re && (mq.size() != 0);
    @(posedge clk);
    m_werr = we && !wacc;
    m_rerr = re && !racc;
    if (racc) begin
      m_dout_s = mq[0];
      void'(mq.pop_front());
    end
    if (wacc)
      for (int i = R - 1; i >= 0; i--) mq.push_back(d[i*DOUT_W +: DOUT_W]);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic we);
    rst = 1'b1; wr_en = we; din = $urandom; rd_en = 1'b0;
    @(posedge clk);
    mq.delete();
    m_werr = 1'b0; m_rerr = 1'b0; m_dout_s = '0;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    m_werr = 1'b0; m_rerr = 1'b0; m_dout_s = '0;
    do_reset(1'b0);
    step(1'b0, '0, 1'b0);

    // Single word, two sub-word reads.
    step(1'b1, 32'hA5A51234, 1'b0);
    chk("tp_first_hi", 32'(dout_f), 32'hA5A5);
    step(1'b0, '0, 1'b1);
    chk("tp_second_lo", 32'(dout_f), 32'h1234);
    step(1'b0, '0, 1'b1);
    chk("tp_empty", 32'(empty_f), 32'd1);

    // Fill to full, overflow attempt.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, $urandom, 1'b0);
      chk("tp_afull_edge", 32'(af_f), 32'(i >= DEPTH - AFM - 1));
    end
    chk("tp_full_level", 32'(level_f), 32'(DEPTH * R));
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("tp_ovf_pulse", 32'(werr_f), 32'd1);
    step(1'b0, '0, 1'b0);
    chk("tp_ovf_single", 32'(werr_f), 32'd0);

    // Full with sel at last sub-word: read frees an entry, write still rejected.
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h1111_2222, 1'b1);
    chk("tp_full_rel", 32'(full_f), 32'd0);
    chk("tp_full_werr", 32'(werr_f), 32'd1);

    for (int i = 0; i < 2 * DEPTH * R && mq.size() != 0; i++) step(1'b0, '0, 1'b1);
    chk("tp_drained", 32'(empty_f), 32'd1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("tp_rerr_b2b", 32'(rerr_f), 32'd1);

    // Standard-read latency and hold.
    step(1'b1, 32'hDEADBEEF, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("tp_std_dead", 32'(dout_s), 32'hDEAD);
    step(1'b0, '0, 1'b0);
    chk("tp_std_hold", 32'(dout_s), 32'hDEAD);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Reset mid-stream discards contents.
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, i[0]);
    do_reset(1'b1);
    chk("tp_rst_level", 32'(level_f), 32'd0);
    step(1'b1, 32'h0001_0002, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("tp_rst_rd0", 32'(dout_s), 32'h0001);
    step(1'b0, '0, 1'b1);
    chk("tp_rst_rd1", 32'(dout_s), 32'h0002);

    // Random traffic in phases of varying write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 50;
      rp = (ph % 3 == 0) ? 40 : (ph % 3 == 1) ? 90 : 50;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
        else step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
